fetch_unit: RTL

Instruction fetch stage of the nemesys core. It owns the program counter, drives the address into the instruction memory (combinational read, same-cycle `inst`), and captures each returned word with its PC into a 2-entry fetch queue. Decode drains the queue through a valid/ready handshake. Execute redirects fetch on taken branches by supplying an absolute target; redirect flushes the queue.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the nemesys core.
// Owns the PC, reads the instruction memory combinationally, and buffers each
// {pc, inst} pair in a 2-entry queue that decode drains through out_valid/out_ready.
// Optional feature macro: FETCH_BOUNDS_EN (sticky out-of-bounds fault and fetch halt).
//
// Handshake: an entry transfers on a cycle where out_valid=1 and out_ready=1;
// the head (out_inst/out_pc) stays stable while out_valid=1 and out_ready=0,
// and out_valid never depends combinationally on out_ready.

`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       pc,
  input  logic [`WIDTH-1:0] inst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [`WIDTH-1:0] out_inst,
  output logic [31:0]       out_pc,
  output logic              fault
);

  // Queue storage: slot 0 is always the head, slot 1 the second-oldest entry.
  logic [1:0]        count;
  logic [31:0]       q_pc   [2];
  logic [`WIDTH-1:0] q_inst [2];

  logic halt;
  logic redir;
  logic deq;
  logic enq;

`ifdef FETCH_BOUNDS_EN
  logic oob;
  assign oob  = (pc >= 32'(MEM_DEPTH));
  assign halt = oob | fault;

  // Sticky fault: set the first time the PC sits out of bounds while a push would be possible.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (oob && (count != 2'd2)) begin
      fault <= 1'b1;
    end
  end
`else
  assign halt  = 1'b0;
  assign fault = 1'b0;
  // The depth only matters for the bounds check; keep it referenced so the
  // default build elaborates it without complaint.
  logic unused_depth;
  assign unused_depth = (pc >= 32'(MEM_DEPTH));
`endif

  // A halted unit ignores redirects entirely so the faulting state stays frozen.
  assign redir     = redirect_valid & ~halt;
  assign out_valid = (count != 2'd0);
  assign deq       = out_valid & out_ready;
  assign enq       = ~redirect_valid & ~halt & ((count != 2'd2) | deq);
  assign out_pc    = q_pc[0];
  assign out_inst  = q_inst[0];

  // PC and occupancy: reset beats redirect, redirect beats normal push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= 2'd0;
    end else if (redir) begin
      pc    <= redirect_target;
      count <= 2'd0;
    end else begin
      if (enq) begin
        pc <= pc + 32'd1;
      end
      count <= count + {1'b0, enq} - {1'b0, deq};
    end
  end

  // Queue payload: shift on pop, then write the new entry into the first free slot.
  // Payload needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (deq) begin
      q_pc[0]   <= q_pc[1];
      q_inst[0] <= q_inst[1];
    end
    if (enq) begin
      if ((count == 2'd0) || ((count == 2'd1) && deq)) begin
        q_pc[0]   <= pc;
        q_inst[0] <= inst;
      end else begin
        q_pc[1]   <= pc;
        q_inst[1] <= inst;
      end
    end
  end

endmodule
